// File: rtl/regfile_cmd_ctrl_pkg.sv
// Shared constants and state encoding for the UART-to-register-file command controller.
// Optional inter-byte timeout is built when REGFILE_CMD_TIMEOUT_EN is defined.
package regfile_cmd_ctrl_pkg;

    localparam int unsigned DATA_W             = 8;
    localparam int unsigned RF_ADDR_W          = 4;
    localparam int unsigned RF_DEPTH           = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

    localparam logic [7:0] OPC_WRITE = 8'hAA;
    localparam logic [7:0] OPC_READ  = 8'hBB;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_EXEC = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_EXEC = 3'd5,
        ST_RD_WAIT = 3'd6,
        ST_TX_WAIT = 3'd7
    } state_e;

endpackage

// File: rtl/regfile_cmd_timer.sv
// Clearable, saturating inter-byte timeout counter with a combinational one-cycle expiry.
// Instantiated only when REGFILE_CMD_TIMEOUT_EN is defined.
module regfile_cmd_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Counts idle cycles while running; any accepted byte or leaving the wait states restarts it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt <= '0;
        end else if (!i_run || i_clr) begin
            cnt <= '0;
        end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign o_expired_c = i_run && !i_clr && (cnt == CNT_LAST);

endmodule

// File: rtl/regfile_cmd_ctrl.sv
// UART byte-stream command controller: parses write/read frames and drives the register file port.
// Define REGFILE_CMD_TIMEOUT_EN to abort frames stalled for TIMEOUT_CYCLES between bytes.
module regfile_cmd_ctrl
    import regfile_cmd_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = DATA_W,
    parameter int unsigned ADD_SIZE = RF_ADDR_W,
    parameter int unsigned RF_SIZE  = RF_DEPTH
`ifdef REGFILE_CMD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [WIDTH-1:0]    i_rx_data,
    input  logic                i_rx_valid,
    input  logic                i_tx_busy,
    output logic [WIDTH-1:0]    o_tx_data,
    output logic                o_tx_valid,
    output logic [ADD_SIZE-1:0] o_rf_add,
    output logic [WIDTH-1:0]    o_rf_data,
    output logic                o_rf_en_w,
    output logic                o_rf_en_r,
    input  logic [WIDTH-1:0]    i_rf_data,
    output logic                o_busy,
    output logic                o_cmd_err
);

    state_e              state, state_d;
    logic [ADD_SIZE-1:0] addr_q, addr_d;
    logic [ADD_SIZE-1:0] rf_add_d;
    logic [WIDTH-1:0]    rf_data_d, tx_data_d;
    logic                en_w_d, en_r_d, tx_valid_d, cmd_err_d;
    logic                addr_ok_c;
    logic                timeout_c;

`ifdef REGFILE_CMD_TIMEOUT_EN
    logic timer_run_c;

    assign timer_run_c = (state == ST_WR_ADDR) || (state == ST_WR_DATA) || (state == ST_RD_ADDR);

    regfile_cmd_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_run       (timer_run_c),
        .i_clr       (i_rx_valid),
        .o_expired_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Address byte must fit the implemented register range with no stray high bits.
    assign addr_ok_c = (i_rx_data[WIDTH-1:ADD_SIZE] == '0) && (32'(i_rx_data) < RF_SIZE);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            o_rf_add   <= '0;
            o_rf_data  <= '0;
            o_rf_en_w  <= 1'b0;
            o_rf_en_r  <= 1'b0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_cmd_err  <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            state      <= state_d;
            addr_q     <= addr_d;
            o_rf_add   <= rf_add_d;
            o_rf_data  <= rf_data_d;
            o_rf_en_w  <= en_w_d;
            o_rf_en_r  <= en_r_d;
            o_tx_data  <= tx_data_d;
            o_tx_valid <= tx_valid_d;
            o_cmd_err  <= cmd_err_d;
            o_busy     <= (state_d != ST_IDLE);
        end
    end

    // Next-state and next-output values; strobes are decided one edge ahead so they leave registered.
    always_comb begin
        state_d    = state;
        addr_d     = addr_q;
        rf_add_d   = o_rf_add;
        rf_data_d  = o_rf_data;
        tx_data_d  = o_tx_data;
        en_w_d     = 1'b0;
        en_r_d     = 1'b0;
        tx_valid_d = 1'b0;
        cmd_err_d  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == WIDTH'(OPC_WRITE)) begin
                        state_d = ST_WR_ADDR;
                    end else if (i_rx_data == WIDTH'(OPC_READ)) begin
                        state_d = ST_RD_ADDR;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_WR_ADDR: begin
                if (i_rx_valid) begin
                    if (addr_ok_c) begin
                        addr_d  = i_rx_data[ADD_SIZE-1:0];
                        state_d = ST_WR_DATA;
                    end else begin
                        cmd_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else if (timeout_c) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (i_rx_valid) begin
                    rf_add_d  = addr_q;
                    rf_data_d = i_rx_data;
                    en_w_d    = 1'b1;
                    state_d   = ST_WR_EXEC;
                end else if (timeout_c) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WR_EXEC: state_d = ST_IDLE;
            ST_RD_ADDR: begin
                if (i_rx_valid) begin
                    if (addr_ok_c) begin
                        rf_add_d = i_rx_data[ADD_SIZE-1:0];
                        en_r_d   = 1'b1;
                        state_d  = ST_RD_EXEC;
                    end else begin
                        cmd_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else if (timeout_c) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_EXEC: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                tx_data_d = i_rf_data;
                if (!i_tx_busy) begin
                    tx_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                if (!i_tx_busy) begin
                    tx_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Directed bench for regfile_cmd_ctrl with a register-file model and write/read scoreboards.
// Timeout steps are exercised when REGFILE_CMD_TIMEOUT_EN is defined (TIMEOUT_CYCLES=16).
module tb_regfile_cmd_ctrl;

    typedef struct packed {
        logic [3:0] add;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [3:0] rf_add;
    logic [7:0] rf_wdata;
    logic       rf_en_w;
    logic       rf_en_r;
    logic [7:0] rf_rdata;
    logic       busy;
    logic       cmd_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned err_seen = 0;
    int unsigned err_exp  = 0;

    logic [7:0] exp_tx[$];
    wr_t        exp_wr[$];
    logic [7:0] exp_mem[16];

    logic [7:0] rf_mem[16];
    logic       rf_loaded = 1'b0;

    always #5 clk = ~clk;

`ifdef REGFILE_CMD_TIMEOUT_EN
    regfile_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .i_tx_busy  (tx_busy),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .o_rf_add   (rf_add),
        .o_rf_data  (rf_wdata),
        .o_rf_en_w  (rf_en_w),
        .o_rf_en_r  (rf_en_r),
        .i_rf_data  (rf_rdata),
        .o_busy     (busy),
        .o_cmd_err  (cmd_err)
    );
`else
    regfile_cmd_ctrl dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .i_tx_busy  (tx_busy),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .o_rf_add   (rf_add),
        .o_rf_data  (rf_wdata),
        .o_rf_en_w  (rf_en_w),
        .o_rf_en_r  (rf_en_r),
        .i_rf_data  (rf_rdata),
        .o_busy     (busy),
        .o_cmd_err  (cmd_err)
    );
`endif

    // Register file: reset contents reg2=0x21, reg3=0x08, registered read data.
    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 8'h00;
            rf_mem[2] <= 8'h21;
            rf_mem[3] <= 8'h08;
            rf_loaded <= 1'b1;
            rf_rdata  <= 8'h00;
        end else begin
            if (rf_en_w) rf_mem[rf_add] <= rf_wdata;
            if (rf_en_r) rf_rdata <= rf_mem[rf_add];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops scoreboards on strobes and counts error pulses.
    always @(negedge clk) begin
        check("en_overlap", 32'(rf_en_w & rf_en_r), 32'd0);
        if (tx_valid) begin
            check("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
            if (exp_tx.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
        if (rf_en_w) begin
            check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) check("wr_payload", 32'({rf_add, rf_wdata}), 32'(exp_wr.pop_front()));
        end
        if (cmd_err) err_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        wr_t w;
        w.add  = a;
        w.data = d;
        exp_wr.push_back(w);
        exp_mem[a] = d;
        send_byte(8'hAA);
        send_byte(8'(a));
        send_byte(d);
        check("wr_strobe", 32'(rf_en_w), 32'd1);
        tick(1);
        check("wr_one_cycle", 32'(rf_en_w), 32'd0);
    endtask

    // Read with TX idle: data byte must appear exactly three cycles after the address byte.
    task automatic do_read(input logic [3:0] a);
        exp_tx.push_back(exp_mem[a]);
        send_byte(8'hBB);
        send_byte(8'(a));
        check("rd_strobe", 32'({rf_en_r, rf_add}), 32'({1'b1, a}));
        tick(1);
        check("rd_tx_early", 32'({rf_en_r, tx_valid}), 32'd0);
        tick(1);
        check("rd_tx_valid", 32'(tx_valid), 32'd1);
        check("rd_tx_byte", 32'(tx_data), 32'(exp_mem[a]));
        tick(1);
        check("rd_tx_pulse", 32'({tx_valid, busy}), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({tx_data, tx_valid, rf_add, rf_wdata, rf_en_w, rf_en_r, busy, cmd_err}), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        exp_mem[2] = 8'h21;
        exp_mem[3] = 8'h08;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        tick(3);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        tick(2);

        // Write then read back
        do_write(4'h5, 8'h5C);
        do_read(4'h5);
        check("no_err_wr_rd", err_seen, err_exp);

        // Reset defaults
        do_read(4'h2);
        do_read(4'h3);
        do_read(4'h0);

        // TX back-pressure with a byte sent while busy
        tx_busy = 1'b1;
        exp_tx.push_back(exp_mem[5]);
        send_byte(8'hBB);
        send_byte(8'h05);
        check("bp_rd_strobe", 32'(rf_en_r), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (i == 4) begin
                rx_data  = 8'hBB;
                rx_valid = 1'b1;
            end
            if (i == 5) rx_valid = 1'b0;
            check("bp_hold_valid", 32'(tx_valid), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            if (i >= 1) check("bp_data_stable", 32'(tx_data), 32'h5C);
        end
        tx_busy = 1'b0;
        tick(1);
        check("bp_valid", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h5C}));
        tick(1);
        check("bp_single", 32'({tx_valid, busy}), 32'd0);
        tick(3);
        check("bp_drop", 32'({busy, rf_en_r}), 32'd0);
        check("bp_data_hold", 32'(tx_data), 32'h5C);

        // Bad opcode
        send_byte(8'h3C);
        err_exp++;
        check("badop_err", 32'({cmd_err, busy}), 32'({1'b1, 1'b0}));
        tick(1);
        check("badop_pulse", 32'(cmd_err), 32'd0);

        // Bad address in a write frame
        send_byte(8'hAA);
        send_byte(8'h1F);
        err_exp++;
        check("badaddr_err", 32'({cmd_err, busy, rf_en_w}), 32'({1'b1, 1'b0, 1'b0}));
        tick(1);
        check("badaddr_pulse", 32'({cmd_err, rf_en_w}), 32'd0);
        do_write(4'h1, 8'h77);
        do_read(4'h1);

        // Async reset mid-frame
        do_write(4'h4, 8'h3A);
        send_byte(8'hAA);
        send_byte(8'h04);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset_async");
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check_all_zero("mid_reset_idle");
        do_read(4'h4);

`ifdef REGFILE_CMD_TIMEOUT_EN
        // 16 idle cycles after the opcode abort the frame
        send_byte(8'hAA);
        tick(15);
        check("to_pending", 32'({cmd_err, busy}), 32'({1'b0, 1'b1}));
        tick(1);
        err_exp++;
        check("to_expire", 32'({cmd_err, busy}), 32'({1'b1, 1'b0}));
        tick(1);
        check("to_pulse", 32'(cmd_err), 32'd0);

        // A 15-cycle gap is still accepted
        send_byte(8'hAA);
        tick(14);
        send_byte(8'h06);
        check("gap_addr", 32'({cmd_err, busy}), 32'({1'b0, 1'b1}));
        begin
            wr_t w;
            w.add  = 4'h6;
            w.data = 8'h66;
            exp_wr.push_back(w);
            exp_mem[6] = 8'h66;
        end
        send_byte(8'h66);
        check("gap_wr_strobe", 32'({rf_en_w, rf_add, rf_wdata}), 32'({1'b1, 4'h6, 8'h66}));
        tick(1);
        do_read(4'h6);
`endif

        tick(2);
        check("err_count", err_seen, err_exp);
        check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
